// File: rtl/fetch_inst_buf_pkg.sv
// Shared width configuration for the fetch instruction buffer.
// Widths default here unless the CPU configuration has already defined them.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

package fetch_inst_buf_pkg;
  localparam int ADDR_W = `AddrWidth;
  localparam int INST_W = `InstWidth;
endpackage

// File: rtl/fetch_inst_buf_ram.sv
// Register-array storage for the fetch queue.
// One synchronous write port and one asynchronous read port.
module fetch_inst_buf_ram
  import fetch_inst_buf_pkg::*;
#(
  parameter int W     = ADDR_W + INST_W,
  parameter int DEPTH = 4,
  parameter int PTR   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en,
  input  logic [PTR-1:0] wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic [PTR-1:0] rd_addr,
  output logic [W-1:0]   rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_inst_buf.sv
// Instruction queue between ICache responses and decode.
// First-word fall-through head; flush drains everything in one cycle.
module fetch_inst_buf
  import fetch_inst_buf_pkg::*;
#(
  parameter  int ADDR  = ADDR_W,
  parameter  int INST  = INST_W,
  parameter  int DEPTH = 4,
  localparam int PTR   = $clog2(DEPTH),
  localparam int CNT   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_,
  input  logic            in_e_,
  input  logic [ADDR-1:0] in_pc,
  input  logic [INST-1:0] in_inst,
  output logic            buf_full,
  output logic [CNT-1:0]  buf_cnt,
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic [INST-1:0] inst,
  input  logic            dec_stall
);

  logic [PTR-1:0]       wr_ptr;
  logic [PTR-1:0]       rd_ptr;
  logic [CNT-1:0]       cnt;
  logic                 push;
  logic                 pop;
  logic [ADDR+INST-1:0] rd_data;

  // buf_full depends only on cnt, so dec_stall never reaches it combinationally.
  assign buf_full = (cnt == CNT'(DEPTH));
  assign buf_cnt  = cnt;
  assign inst_e_  = (cnt == '0);
  assign push     = !in_e_ && !buf_full;
  assign pop      = !inst_e_ && !dec_stall;

  always_ff @(posedge clk) begin
    if (reset || !flush_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR'(1);
      if (push && !pop)      cnt <= cnt + CNT'(1);
      else if (!push && pop) cnt <= cnt - CNT'(1);
    end
  end

  fetch_inst_buf_ram #(
    .W     (ADDR + INST),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push && flush_),
    .wr_addr (wr_ptr),
    .wr_data ({in_pc, in_inst}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign {inst_pc, inst} = rd_data;

endmodule

// File: tb/tb_fetch_inst_buf.sv
// Directed bench for fetch_inst_buf: ordering, full/stall, steady state, flush and reset.
module tb_fetch_inst_buf;
  localparam int DEPTH = 4;
  localparam int CNT   = $clog2(DEPTH + 1);

  logic            clk = 0;
  logic            reset, flush_, in_e_, dec_stall;
  logic [31:0]     in_pc, in_inst;
  logic            buf_full, inst_e_;
  logic [CNT-1:0]  buf_cnt;
  logic [31:0]     inst_pc, inst;

  int n_chk  = 0;
  int n_pass = 0;
  int viol   = 0;

  fetch_inst_buf #(.ADDR(32), .INST(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush_    (flush_),
    .in_e_     (in_e_),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .buf_full  (buf_full),
    .buf_cnt   (buf_cnt),
    .inst_e_   (inst_e_),
    .inst_pc   (inst_pc),
    .inst      (inst),
    .dec_stall (dec_stall)
  );

  always #5 clk = ~clk;

  // Protocol violations seen by the bench (fetch while full).
  always @(posedge clk) if (!reset && flush_ && !in_e_ && buf_full) viol++;

  a_cnt_max: assert property (@(posedge clk) dut.cnt <= CNT'(DEPTH));
  a_no_push_full: assert property (@(posedge clk)
    (!reset && flush_ && !in_e_ && buf_full) |=> $stable(dut.wr_ptr));
  a_head_stable: assert property (@(posedge clk)
    (!reset && flush_ && dec_stall && !inst_e_) |=>
      (!inst_e_ && $stable(inst_pc) && $stable(inst)));

  function automatic logic [31:0] iw(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc);
    in_e_   = !en;
    in_pc   = pc;
    in_inst = iw(pc);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input int c);
    chk({tag, "_e"},   64'(inst_e_), 64'(c == 0));
    chk({tag, "_pc"},  64'(inst_pc), 64'(pc));
    chk({tag, "_in"},  64'(inst),    64'(iw(pc)));
    chk({tag, "_cnt"}, 64'(buf_cnt), 64'(c));
  endtask

  initial begin
    reset = 1; flush_ = 1; dec_stall = 0;
    drive(0, 32'h0);
    step(); step();
    reset = 0;
    chk("rst_e", 64'(inst_e_), 64'd1);
    chk("rst_full", 64'(buf_full), 64'd0);
    chk("rst_cnt", 64'(buf_cnt), 64'd0);
    chk("rst_pc", 64'(inst_pc), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);

    // 1: three pushes with decode free-running
    drive(1, 32'h100);
    #1;
    chk("t1_nobypass", 64'(inst_e_), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 32'(4 * i));
      step();
      chk_head("t1_head", 32'h100 + 32'(4 * i), 1);
    end
    drive(0, 32'h0);
    step();
    chk("t1_empty", 64'(inst_e_), 64'd1);

    // 2: fill under stall, drop the fifth, drain
    dec_stall = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h300 + 32'(4 * i));
      step();
      chk("t2_cnt", 64'(buf_cnt), 64'(i + 1));
      chk("t2_hold_pc", 64'(inst_pc), 64'h300);
    end
    chk("t2_full", 64'(buf_full), 64'd1);
    drive(1, 32'h310);
    step();
    chk("t2_viol", 64'(viol), 64'd1);
    chk_head("t2_drop", 32'h300, 4);
    drive(0, 32'h0);
    dec_stall = 0;
    step();
    chk("t2_full_drop", 64'(buf_full), 64'd0);
    chk_head("t2_pop1", 32'h304, 3);
    step();
    chk_head("t2_pop2", 32'h308, 2);
    step();
    chk_head("t2_pop3", 32'h30C, 1);
    step();
    chk("t2_empty", 64'(inst_e_), 64'd1);
    chk("t2_cnt0", 64'(buf_cnt), 64'd0);

    // 3: steady state at cnt=2 with push+pop every cycle
    dec_stall = 1;
    drive(1, 32'h400); step();
    drive(1, 32'h404); step();
    chk_head("t3_pre", 32'h400, 2);
    dec_stall = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h408 + 32'(4 * k));
      step();
      chk_head("t3_ss", 32'h404 + 32'(4 * k), 2);
    end
    drive(0, 32'h0);
    step();
    chk_head("t3_dr1", 32'h42C, 1);
    step();
    chk("t3_empty", 64'(inst_e_), 64'd1);

    // 4: flush with a concurrent push and pop
    dec_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h500 + 32'(4 * i));
      step();
    end
    chk_head("t4_pre", 32'h500, 3);
    dec_stall = 0;
    flush_ = 0;
    drive(1, 32'h50C);
    step();
    chk("t4_fl_e", 64'(inst_e_), 64'd1);
    chk("t4_fl_cnt", 64'(buf_cnt), 64'd0);
    flush_ = 1;
    drive(1, 32'h200);
    step();
    chk_head("t4_after", 32'h200, 1);
    drive(0, 32'h0);
    step();
    chk("t4_empty", 64'(inst_e_), 64'd1);

    // 5: reset and flush together mid-stall
    dec_stall = 1;
    drive(1, 32'h600); step();
    drive(1, 32'h604); step();
    chk_head("t5_pre", 32'h600, 2);
    drive(0, 32'h0);
    reset = 1;
    flush_ = 0;
    step();
    chk("t5_e", 64'(inst_e_), 64'd1);
    chk("t5_full", 64'(buf_full), 64'd0);
    chk("t5_cnt", 64'(buf_cnt), 64'd0);
    chk("t5_pc", 64'(inst_pc), 64'd0);
    chk("t5_inst", 64'(inst), 64'd0);
    reset = 0;
    flush_ = 1;
    dec_stall = 0;
    drive(1, 32'h700);
    step();
    chk_head("t5_post", 32'h700, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
